// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl
// Write-side controller for a dual-clock FIFO. Everything here runs in the
// write clock domain. It keeps the binary and Gray write pointers, drives the
// memory write address/enable, and derives registered full, almost-full and
// fill-level outputs from the Gray read pointer. That read pointer has already
// been synchronised into wclk. It also keeps a sticky overflow flag.
//
// Ports:
//   wclk          write clock, all state changes on its rising edge
//   wrst_n        synchronous active-low reset
//   winc          write request from the producer
//   wovf_clr      clears the sticky overflow flag (a new overflow wins)
//   sync_rd_ptr   Gray read pointer, already synchronised into wclk
//   wen           memory write enable, winc & ~wfull
//   waddr         memory write address (low bits of binary write pointer)
//   wptr          registered Gray write pointer for the read-side synchroniser
//   wfull         registered full flag
//   walmost_full  registered almost-full flag (level >= AFULL_LVL)
//   wlevel        registered fill level, 0..DEPTH
//   wovf          sticky overflow flag

module fifo_wr_ctrl #(
  parameter int ADDR_W    = 3,
  parameter int AFULL_LVL = 6
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              winc,
  input  logic              wovf_clr,
  input  logic [ADDR_W:0]   sync_rd_ptr,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr,
  output logic              wfull,
  output logic              walmost_full,
  output logic [ADDR_W:0]   wlevel,
  output logic              wovf
);

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0] AFULL_V = (ADDR_W+1)'(AFULL_LVL);

  logic [ADDR_W:0] wbin_q, wbin_d;
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] wlevel_q, wlevel_d;
  logic            wfull_q, wfull_d;
  logic            wafull_q, wafull_d;
  logic            wovf_q, wovf_d;
  logic [ADDR_W:0] rbin;

  // Next-state logic. The accepted write and the latest read pointer are
  // folded into the same level computation. A write plus a freed entry in one
  // cycle therefore leaves the level unchanged. The pointer width carries one
  // extra wrap bit, so the modulo subtraction stays within 0..DEPTH across
  // wrap-around. wen depends only on winc and the registered full flag. It has
  // no path from sync_rd_ptr. A late read pointer can only make the flags
  // pessimistic, never optimistic.
  always_comb begin
    wen      = winc & ~wfull_q;
    rbin     = '0;
    wbin_d   = wbin_q + {{ADDR_W{1'b0}}, wen};
    wptr_d   = (wbin_d >> 1) ^ wbin_d;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it.
    for (int i = 0; i <= ADDR_W; i++) begin
      rbin[i] = ^(sync_rd_ptr >> i);
    end

    wlevel_d = wbin_d - rbin;
    wfull_d  = (wlevel_d == DEPTH_V);
    wafull_d = (wlevel_d >= AFULL_V);

    // Overflow is sticky. A new overflow in the same cycle beats a clear.
    wovf_d = wovf_q;
    if (winc & wfull_q) begin
      wovf_d = 1'b1;
    end else if (wovf_clr) begin
      wovf_d = 1'b0;
    end
  end

  // State registers. Reset discards all pointer state, whatever winc is doing.
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr        = wbin_q[ADDR_W-1:0];
  assign wptr         = wptr_q;
  assign wlevel       = wlevel_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wovf         = wovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl
// Directed self-checking bench for fifo_wr_ctrl with ADDR_W=3, AFULL_LVL=6.
// Inputs change 1 time unit after the rising edge. Outputs are also sampled
// there, well away from the active edge.

module tb_fifo_wr_ctrl;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       winc = 1'b0;
  logic       wovf_clr = 1'b0;
  logic [3:0] sync_rd_ptr = 4'h0;
  logic       wen;
  logic [2:0] waddr;
  logic [3:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [3:0] wlevel;
  logic       wovf;

  int total = 0;
  int bad   = 0;

  fifo_wr_ctrl #(.ADDR_W(3), .AFULL_LVL(6)) dut (
    .wclk(wclk),
    .wrst_n(wrst_n),
    .winc(winc),
    .wovf_clr(wovf_clr),
    .sync_rd_ptr(sync_rd_ptr),
    .wen(wen),
    .waddr(waddr),
    .wptr(wptr),
    .wfull(wfull),
    .walmost_full(walmost_full),
    .wlevel(wlevel),
    .wovf(wovf)
  );

  // 10-unit write clock.
  always #5 wclk = ~wclk;

  // Advance one rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reset is held with winc=1 for three edges. All state must stay zero, and
  // wen must keep following winc.
  task automatic test_reset();
    wrst_n = 1'b0; winc = 1'b1; wovf_clr = 1'b0; sync_rd_ptr = 4'h0;
    repeat (3) step();
    total++; if (wptr !== 4'h0) begin bad++; $display("[TB] FAIL reset_wptr got=%h want=0", wptr); end
    total++; if (waddr !== 3'd0) begin bad++; $display("[TB] FAIL reset_waddr got=%0d want=0", waddr); end
    total++; if (wlevel !== 4'd0) begin bad++; $display("[TB] FAIL reset_wlevel got=%0d want=0", wlevel); end
    total++; if (wfull !== 1'b0) begin bad++; $display("[TB] FAIL reset_wfull got=%b want=0", wfull); end
    total++; if (walmost_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_wafull got=%b want=0", walmost_full); end
    total++; if (wovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_wovf got=%b want=0", wovf); end
    total++; if (wen !== 1'b1) begin bad++; $display("[TB] FAIL reset_wen got=%b want=1", wen); end
    winc = 1'b0;
    wrst_n = 1'b1;
    step();
  endtask

  // Eight back-to-back writes with the read pointer parked at 0.
  task automatic test_fill();
    logic [3:0] exp_gray [8];
    exp_gray = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
    sync_rd_ptr = 4'h0;
    winc = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      total++; if (wptr !== exp_gray[i-1]) begin bad++; $display("[TB] FAIL fill_wptr[%0d] got=%h want=%h", i, wptr, exp_gray[i-1]); end
      total++; if (waddr !== 3'(i % 8)) begin bad++; $display("[TB] FAIL fill_waddr[%0d] got=%0d want=%0d", i, waddr, i % 8); end
      total++; if (wlevel !== 4'(i)) begin bad++; $display("[TB] FAIL fill_wlevel[%0d] got=%0d want=%0d", i, wlevel, i); end
      total++; if (walmost_full !== (i >= 6)) begin bad++; $display("[TB] FAIL fill_wafull[%0d] got=%b want=%b", i, walmost_full, (i >= 6)); end
      total++; if (wfull !== (i == 8)) begin bad++; $display("[TB] FAIL fill_wfull[%0d] got=%b want=%b", i, wfull, (i == 8)); end
    end
  endtask

  // Writes while full are refused and set the sticky overflow. A clear only
  // takes effect in a cycle with no fresh overflow.
  task automatic test_overflow();
    winc = 1'b1;
    total++; if (wen !== 1'b0) begin bad++; $display("[TB] FAIL ovf_wen got=%b want=0", wen); end
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (wptr !== 4'hC) begin bad++; $display("[TB] FAIL ovf_wptr[%0d] got=%h want=c", i, wptr); end
      total++; if (wovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set[%0d] got=%b want=1", i, wovf); end
      total++; if (wlevel !== 4'd8) begin bad++; $display("[TB] FAIL ovf_wlevel[%0d] got=%0d want=8", i, wlevel); end
    end
    wovf_clr = 1'b1;
    step();
    total++; if (wovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set_wins got=%b want=1", wovf); end
    winc = 1'b0;
    step();
    total++; if (wovf !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clear got=%b want=0", wovf); end
    wovf_clr = 1'b0;
  endtask

  // The read side frees three entries (Gray 2 = binary 3) while the FIFO is full.
  task automatic test_drain();
    winc = 1'b0;
    sync_rd_ptr = 4'h2;
    total++; if (wen !== 1'b0) begin bad++; $display("[TB] FAIL drain_wen_no_rd_path got=%b want=0", wen); end
    step();
    total++; if (wlevel !== 4'd5) begin bad++; $display("[TB] FAIL drain_wlevel got=%0d want=5", wlevel); end
    total++; if (wfull !== 1'b0) begin bad++; $display("[TB] FAIL drain_wfull got=%b want=0", wfull); end
    total++; if (walmost_full !== 1'b0) begin bad++; $display("[TB] FAIL drain_wafull got=%b want=0", walmost_full); end
  endtask

  // Raise the level to 7. Then write once while the read pointer advances by
  // one entry (binary 3 -> 4, Gray 6) in the same cycle.
  task automatic test_simultaneous();
    winc = 1'b1;
    step();
    step();
    total++; if (wlevel !== 4'd7) begin bad++; $display("[TB] FAIL simul_pre_wlevel got=%0d want=7", wlevel); end
    sync_rd_ptr = 4'h6;
    step();
    winc = 1'b0;
    total++; if (wlevel !== 4'd7) begin bad++; $display("[TB] FAIL simul_wlevel got=%0d want=7", wlevel); end
    total++; if (wfull !== 1'b0) begin bad++; $display("[TB] FAIL simul_wfull got=%b want=0", wfull); end
    total++; if (walmost_full !== 1'b1) begin bad++; $display("[TB] FAIL simul_wafull got=%b want=1", walmost_full); end
    total++; if (waddr !== 3'd3) begin bad++; $display("[TB] FAIL simul_waddr got=%0d want=3", waddr); end
  endtask

  // From a fresh reset, stream 40 writes. The read pointer trails the
  // committed write count by two entries. Both waddr and wptr must wrap.
  task automatic test_wrap();
    int         wb;
    int         rb;
    int         exp_lvl;
    logic [2:0] prev_addr;
    logic [3:0] prev_ptr;
    logic       addr_wrap;
    logic       ptr_wrap;
    wrst_n = 1'b0; winc = 1'b0; sync_rd_ptr = 4'h0;
    step();
    wrst_n = 1'b1;
    wb = 0;
    addr_wrap = 1'b0;
    ptr_wrap = 1'b0;
    for (int k = 0; k < 40; k++) begin
      rb = (wb >= 2) ? wb - 2 : 0;
      sync_rd_ptr = to_gray(4'(rb % 16));
      winc = 1'b1;
      prev_addr = waddr;
      prev_ptr = wptr;
      step();
      wb++;
      exp_lvl = wb - rb;
      total++; if (wlevel !== 4'(exp_lvl)) begin bad++; $display("[TB] FAIL wrap_wlevel[%0d] got=%0d want=%0d", k, wlevel, exp_lvl); end
      total++; if (wfull !== 1'b0) begin bad++; $display("[TB] FAIL wrap_wfull[%0d] got=%b want=0", k, wfull); end
      total++; if (waddr !== 3'(wb % 8)) begin bad++; $display("[TB] FAIL wrap_waddr[%0d] got=%0d want=%0d", k, waddr, wb % 8); end
      total++; if (wptr !== to_gray(4'(wb % 16))) begin bad++; $display("[TB] FAIL wrap_wptr[%0d] got=%h want=%h", k, wptr, to_gray(4'(wb % 16))); end
      if (prev_addr == 3'd7 && waddr == 3'd0) addr_wrap = 1'b1;
      if (prev_ptr == 4'h8 && wptr == 4'h0) ptr_wrap = 1'b1;
    end
    winc = 1'b0;
    total++; if (addr_wrap !== 1'b1) begin bad++; $display("[TB] FAIL wrap_waddr_seen got=%b want=1", addr_wrap); end
    total++; if (ptr_wrap !== 1'b1) begin bad++; $display("[TB] FAIL wrap_wptr_seen got=%b want=1", ptr_wrap); end
  endtask

  // Run the scenarios in order. Each task starts from the state left by the
  // previous one, except test_wrap, which resets first.
  initial begin
    #1;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_simultaneous();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
